spad_weight_rx: RTL and testbench
=================================

// Module: spad_weight_rx
// PURPOSE
//  PE-side receiver for the GLB->spad weight load stream.
//  - Accepts one word per cycle on w_data_spad while load_en_spad is high.
//  - Stores kernel_size**2 words into the PE weight scratchpad, starting at W_LOAD_ADDR.
//  - Flags completion to the control unit, then serves registered reads to the MAC datapath.
//  - Sits between the weight router (transmitter) and the PE MAC pipeline.
// PARAMETERS
//  DATA_BITWIDTH       16   weight word width
//  ADDR_BITWIDTH_SPAD  9    spad address width; depth = 2**ADDR_BITWIDTH_SPAD
//  kernel_size         3    words per load = kernel_size**2 (9)
//  W_LOAD_ADDR         0    spad base address of the first received word
// PORTS
//  clk            in   1                   clock, all logic on rising edge
//  reset          in   1                   synchronous, active-high
//  load_spad_ctrl in   1                   arm pulse from control unit; starts a new load
//  w_data_spad    in   DATA_BITWIDTH       incoming weight word
//  load_en_spad   in   1                   w_data_spad valid this cycle
//  read_req_spad  in   1                   MAC read request
//  r_addr_spad    in   ADDR_BITWIDTH_SPAD  MAC read address
//  r_data_spad    out  DATA_BITWIDTH       read data, 1-cycle latency
//  r_valid_spad   out  1                   r_data_spad valid
//  load_done      out  1                   1-cycle pulse when final word is stored
//  spad_ready     out  1                   level: full kernel resident (FULL state)
//  wght_count     out  5                   words stored in current load
//  load_err       out  1                   sticky: a word was dropped
// BEHAVIOUR
//  Reset values
//  - All outputs 0; state=IDLE; wr_ptr=W_LOAD_ADDR.
//  - Memory contents are not cleared.
//  State IDLE
//  - load_spad_ctrl: ->LOADING; wght_count<=0; wr_ptr<=W_LOAD_ADDR; load_err<=0.
//  - load_en_spad without arm: word dropped, load_err<=1.
//  State LOADING (per word, i.e. load_en_spad=1)
//  - mem[wr_ptr]<=w_data_spad; wr_ptr+1 (wraps mod 2**ADDR_BITWIDTH_SPAD); wght_count+1.
//  - Word that makes wght_count==kernel_size**2: load_done=1 next cycle, spad_ready<=1, ->FULL.
//  - Gaps in load_en_spad are legal; no timeout.
//  State FULL
//  - Extra words dropped, load_err<=1, memory unchanged.
//  - load_spad_ctrl: ->LOADING, spad_ready<=0, counters rearmed as in IDLE.
//  Arm collisions
//  - load_spad_ctrl while LOADING: restart (count 0, wr_ptr base).
//  - load_spad_ctrl dominates: a word coincident with an arm is dropped without setting load_err.
//  Read port
//  - read_req_spad at cycle t: r_data_spad=mem[r_addr_spad], r_valid_spad=1 at t+1.
//  - r_valid_spad=0 otherwise; r_data_spad holds its last value.
//  - Reads are legal in any state.
//  - Same-address read and write in one cycle returns old data (read-before-write).
//  Reset mid-load
//  - Abort to IDLE; partially written words stay in memory; spad_ready=0.
//  Width
//  - wght_count saturates at kernel_size**2.
//  - kernel_size**2 must be <=31 and <=2**ADDR_BITWIDTH_SPAD; check at elaboration.
// TESTING
//  1. Arm, then 9 back-to-back words 0x0101..0x0109 ->
//     - mem[0..8] match; load_done single pulse the cycle after word 9.
//     - spad_ready=1; wght_count=9; load_err=0.
//  2. Arm, 9 words with 1-3 cycle random gaps -> same results as scenario 1; no early load_done.
//  3. In FULL, send 2 extra words 0xDEAD ->
//     - mem unchanged; load_err=1; spad_ready stays 1; no second load_done.
//  4. Words without prior arm (IDLE) -> dropped, load_err=1, wght_count=0.
//     Then arm -> load_err cleared.
//  5. Arm; 4 words; reset; arm; 9 words 0x0201.. ->
//     - mem[0..8]=0x0201..0x0209; exactly one load_done.
//     - W_LOAD_ADDR=508 variant: wr_ptr wraps 511->0.
//  6. Read addr 3 while writing addr 3 (0xAAAA over 0x5555) ->
//     - r_data_spad=0x5555, r_valid_spad=1 next cycle.
//     - Next read of addr 3 returns 0xAAAA.

Source files
------------

// File: rtl/spad_weight_rx.sv
// PE-side weight scratchpad receiver: loads kernel_size**2 words from the GLB stream, then serves MAC reads.
// Latency: write on the cycle load_en_spad is sampled, read data one cycle after read_req_spad.
// Backpressure: none. Words arriving when no load is armed are dropped and flagged in load_err.
module spad_weight_rx #(
    parameter int DATA_BITWIDTH      = 16,
    parameter int ADDR_BITWIDTH_SPAD = 9,
    parameter int kernel_size        = 3,
    parameter int W_LOAD_ADDR        = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_spad_ctrl,
    input  logic [DATA_BITWIDTH-1:0]      w_data_spad,
    input  logic                          load_en_spad,
    input  logic                          read_req_spad,
    input  logic [ADDR_BITWIDTH_SPAD-1:0] r_addr_spad,
    output logic [DATA_BITWIDTH-1:0]      r_data_spad,
    output logic                          r_valid_spad,
    output logic                          load_done,
    output logic                          spad_ready,
    output logic [4:0]                    wght_count,
    output logic                          load_err
);

    localparam int DEPTH = 1 << ADDR_BITWIDTH_SPAD;
    localparam int K2    = kernel_size * kernel_size;

    generate
        if (K2 > 31 || K2 > DEPTH || K2 < 1) begin : g_bad_cfg
            $error("spad_weight_rx: kernel_size**2 must be 1..31 and fit in the scratchpad");
        end
    endgenerate

    localparam logic [4:0]                    CNT_FULL = 5'(K2);
    localparam logic [4:0]                    CNT_LAST = 5'(K2 - 1);
    localparam logic [ADDR_BITWIDTH_SPAD-1:0] BASE     = ADDR_BITWIDTH_SPAD'(W_LOAD_ADDR);
    localparam logic [ADDR_BITWIDTH_SPAD-1:0] ONE      = ADDR_BITWIDTH_SPAD'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOADING = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_BITWIDTH-1:0]      mem [DEPTH];
    logic [ADDR_BITWIDTH_SPAD-1:0] wr_ptr;
    logic                          last_word;
    logic                          wr_en;
    logic                          set_err;
    logic                          done_nxt;

    assign last_word = (wght_count == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An arm always wins: it restarts the load from any state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (load_spad_ctrl) state_nxt = S_LOADING;
            end
            S_LOADING: begin
                if (load_spad_ctrl)                 state_nxt = S_LOADING;
                else if (load_en_spad && last_word) state_nxt = S_FULL;
            end
            S_FULL: begin
                if (load_spad_ctrl) state_nxt = S_LOADING;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        wr_en      = 1'b0;
        set_err    = 1'b0;
        done_nxt   = 1'b0;
        spad_ready = (state == S_FULL);
        if (!reset && !load_spad_ctrl && load_en_spad) begin
            if (state == S_LOADING) begin
                wr_en    = 1'b1;
                done_nxt = last_word;
            end else begin
                set_err  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= BASE;
            wght_count <= 5'd0;
            load_err   <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            load_done <= done_nxt;
            if (load_spad_ctrl) begin
                wr_ptr     <= BASE;
                wght_count <= 5'd0;
                load_err   <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + ONE;
                    if (wght_count < CNT_FULL) wght_count <= wght_count + 5'd1;
                end
                if (set_err) load_err <= 1'b1;
            end
        end
    end

    // Scratchpad storage is never cleared; only the control state resets.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= w_data_spad;
    end

    // Read samples the pre-write contents, giving read-before-write on collisions.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_spad <= 1'b0;
            r_data_spad  <= '0;
        end else begin
            r_valid_spad <= read_req_spad;
            if (read_req_spad) r_data_spad <= mem[r_addr_spad];
        end
    end

endmodule

// File: tb/tb_spad_weight_rx.sv
// Bench for spad_weight_rx: directed vector table, multi-cycle sequences and random traffic on two
// instances (base 0 and base 508), each checked against a scratchpad-level reference model.
module tb_spad_weight_rx;

    logic        clk = 1'b0;
    logic        rst, arm, en, rd;
    logic [15:0] d;
    logic [8:0]  addr;

    logic [15:0] r_data_o     [2];
    logic        r_valid_o    [2];
    logic        load_done_o  [2];
    logic        spad_ready_o [2];
    logic [4:0]  wght_count_o [2];
    logic        load_err_o   [2];

    always #5 clk = ~clk;

    spad_weight_rx #(.W_LOAD_ADDR(0)) dut0 (
        .clk(clk), .reset(rst), .load_spad_ctrl(arm), .w_data_spad(d), .load_en_spad(en),
        .read_req_spad(rd), .r_addr_spad(addr), .r_data_spad(r_data_o[0]), .r_valid_spad(r_valid_o[0]),
        .load_done(load_done_o[0]), .spad_ready(spad_ready_o[0]), .wght_count(wght_count_o[0]),
        .load_err(load_err_o[0]));

    spad_weight_rx #(.W_LOAD_ADDR(508)) dut1 (
        .clk(clk), .reset(rst), .load_spad_ctrl(arm), .w_data_spad(d), .load_en_spad(en),
        .read_req_spad(rd), .r_addr_spad(addr), .r_data_spad(r_data_o[1]), .r_valid_spad(r_valid_o[1]),
        .load_done(load_done_o[1]), .spad_ready(spad_ready_o[1]), .wght_count(wght_count_o[1]),
        .load_err(load_err_o[1]));

    int n_vec = 0;
    int n_bad = 0;
    int n_done0 = 0;

    // Reference model: phase 0 = waiting for arm, 1 = collecting words, 2 = kernel resident.
    localparam int WORDS = 9;
    int          m_base  [2] = '{0, 508};
    int          m_phase [2];
    int          m_cnt   [2];
    int          m_ptr   [2];
    bit          m_err   [2];
    bit          m_done  [2];
    bit          m_rv    [2];
    bit          m_rdk   [2];
    logic [15:0] m_rdata [2];
    logic [15:0] m_mem   [2][512];
    bit          m_known [2][512];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        if (rst) begin
            m_phase[k] = 0; m_cnt[k] = 0; m_ptr[k] = m_base[k];
            m_err[k] = 0; m_done[k] = 0; m_rv[k] = 0; m_rdata[k] = 16'h0; m_rdk[k] = 1;
        end else begin
            m_done[k] = 0;
            m_rv[k]   = rd;
            if (rd) begin
                m_rdata[k] = m_mem[k][addr];
                m_rdk[k]   = m_known[k][addr];
            end
            if (arm) begin
                m_phase[k] = 1; m_cnt[k] = 0; m_ptr[k] = m_base[k]; m_err[k] = 0;
            end else if (en) begin
                if (m_phase[k] == 1) begin
                    m_mem[k][m_ptr[k]]   = d;
                    m_known[k][m_ptr[k]] = 1;
                    m_ptr[k] = (m_ptr[k] + 1) % 512;
                    m_cnt[k]++;
                    if (m_cnt[k] == WORDS) begin
                        m_phase[k] = 2;
                        m_done[k]  = 1;
                    end
                end else begin
                    m_err[k] = 1;
                end
            end
        end
    endtask

    task automatic compare(input int k);
        string p;
        p = (k == 0) ? "i0" : "i1";
        chk({p, "_load_done"},  32'(load_done_o[k]),  32'(m_done[k]));
        chk({p, "_spad_ready"}, 32'(spad_ready_o[k]), 32'(m_phase[k] == 2));
        chk({p, "_wght_count"}, 32'(wght_count_o[k]), 32'(m_cnt[k]));
        chk({p, "_load_err"},   32'(load_err_o[k]),   32'(m_err[k]));
        chk({p, "_r_valid"},    32'(r_valid_o[k]),    32'(m_rv[k]));
        if (m_rdk[k]) chk({p, "_r_data"}, 32'(r_data_o[k]), 32'(m_rdata[k]));
    endtask

    task automatic cycle();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        compare(0);
        compare(1);
        if (load_done_o[0] === 1'b1) n_done0++;
    endtask

    task automatic op(input bit r, input bit a, input bit e, input logic [15:0] dd,
                      input bit q, input logic [8:0] ad);
        rst = r; arm = a; en = e; d = dd; rd = q; addr = ad;
        cycle();
    endtask

    typedef struct {
        bit r; bit a; bit e; logic [15:0] d; bit q; logic [8:0] ad;
        bit x_done; bit x_ready; logic [4:0] x_cnt; bit x_err; bit x_rv; logic [15:0] x_rdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit a, bit e, logic [15:0] dd, bit q, logic [8:0] ad,
                                bit xd, bit xr, logic [4:0] xc, bit xe, bit xv, logic [15:0] xrd);
        vec_t v;
        v.r = r; v.a = a; v.e = e; v.d = dd; v.q = q; v.ad = ad;
        v.x_done = xd; v.x_ready = xr; v.x_cnt = xc; v.x_err = xe; v.x_rv = xv; v.x_rdata = xrd;
        return v;
    endfunction

    initial begin
        int base_done;
        rst = 1'b1; arm = 1'b0; en = 1'b0; d = '0; rd = 1'b0; addr = '0;
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 512; a++) m_known[k][a] = 0;

        // Directed table on instance 0: reset, unarmed words, 9-word load, overflow, read collision.
        tbl.push_back(mk(1,0,0,16'h0000,0,0,   0,0,0,0,0,16'h0000));
        tbl.push_back(mk(0,0,1,16'hDEAD,0,0,   0,0,0,1,0,16'h0000));
        tbl.push_back(mk(0,0,1,16'hDEAD,0,0,   0,0,0,1,0,16'h0000));
        tbl.push_back(mk(0,1,1,16'h1111,0,0,   0,0,0,0,0,16'h0000));
        for (int i = 1; i <= 9; i++)
            tbl.push_back(mk(0,0,1,16'(16'h0100 + i),0,0, i == 9, i == 9, 5'(i), 0,0,16'h0000));
        tbl.push_back(mk(0,0,0,16'h0000,1,0,   0,1,9,0,1,16'h0101));
        tbl.push_back(mk(0,0,1,16'hDEAD,1,8,   0,1,9,1,1,16'h0109));
        tbl.push_back(mk(0,0,1,16'hDEAD,1,3,   0,1,9,1,1,16'h0104));
        tbl.push_back(mk(0,0,0,16'h0000,0,0,   0,1,9,1,0,16'h0104));
        tbl.push_back(mk(0,1,0,16'h0000,0,0,   0,0,0,0,0,16'h0104));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(0,0,1,16'h5555,0,0, 0,0,5'(i),0,0,16'h0104));
        tbl.push_back(mk(0,1,0,16'h0000,0,0,   0,0,0,0,0,16'h0104));
        for (int i = 1; i <= 3; i++)
            tbl.push_back(mk(0,0,1,16'h0000,0,0, 0,0,5'(i),0,0,16'h0104));
        tbl.push_back(mk(0,0,1,16'hAAAA,1,3,   0,0,4,0,1,16'h5555));
        tbl.push_back(mk(0,0,0,16'h0000,1,3,   0,0,4,0,1,16'hAAAA));
        tbl.push_back(mk(1,0,0,16'h0000,0,0,   0,0,0,0,0,16'h0000));

        foreach (tbl[i]) begin
            op(tbl[i].r, tbl[i].a, tbl[i].e, tbl[i].d, tbl[i].q, tbl[i].ad);
            chk($sformatf("tbl%0d_load_done", i),  32'(load_done_o[0]),  32'(tbl[i].x_done));
            chk($sformatf("tbl%0d_spad_ready", i), 32'(spad_ready_o[0]), 32'(tbl[i].x_ready));
            chk($sformatf("tbl%0d_wght_count", i), 32'(wght_count_o[0]), 32'(tbl[i].x_cnt));
            chk($sformatf("tbl%0d_load_err", i),   32'(load_err_o[0]),   32'(tbl[i].x_err));
            chk($sformatf("tbl%0d_r_valid", i),    32'(r_valid_o[0]),    32'(tbl[i].x_rv));
            chk($sformatf("tbl%0d_r_data", i),     32'(r_data_o[0]),     32'(tbl[i].x_rdata));
        end

        // Reset in the middle of a load, then a clean reload; instance 1 wraps 511 -> 0.
        op(0,1,0,0,0,0);
        for (int i = 0; i < 4; i++) op(0,0,1,16'(16'h0301 + i),0,0);
        op(1,0,0,0,0,0);
        chk("s5_count_after_reset", 32'(wght_count_o[0]), 32'd0);
        chk("s5_ready_after_reset", 32'(spad_ready_o[0]), 32'd0);
        base_done = n_done0;
        op(0,1,0,0,0,0);
        for (int i = 0; i < 9; i++) op(0,0,1,16'(16'h0201 + i),0,0);
        op(0,0,0,0,0,0);
        op(0,0,0,0,0,0);
        chk("s5_done_pulses", 32'(n_done0 - base_done), 32'd1);
        for (int i = 0; i < 9; i++) begin
            op(0,0,0,0,1,9'(i));
            chk($sformatf("s5_i0_mem%0d", i), 32'(r_data_o[0]), 32'(16'h0201 + i));
        end
        for (int i = 0; i < 9; i++) begin
            op(0,0,0,0,1,9'((508 + i) % 512));
            chk($sformatf("s5_i1_mem%0d", (508 + i) % 512), 32'(r_data_o[1]), 32'(16'h0201 + i));
        end

        // Gapped load: no early completion, exactly one pulse at the ninth word.
        base_done = n_done0;
        op(0,1,0,0,0,0);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) repeat ($urandom_range(1, 3)) op(0,0,0,0,0,0);
            if (i == 8) chk("s2_no_early_done", 32'(n_done0 - base_done), 32'd0);
            op(0,0,1,16'(16'h0101 + i),0,0);
        end
        chk("s2_done_pulses", 32'(n_done0 - base_done), 32'd1);
        chk("s2_spad_ready", 32'(spad_ready_o[0]), 32'd1);
        chk("s2_wght_count", 32'(wght_count_o[0]), 32'd9);
        for (int i = 0; i < 9; i++) begin
            op(0,0,0,0,1,9'(i));
            chk($sformatf("s2_mem%0d", i), 32'(r_data_o[0]), 32'(16'h0101 + i));
        end

        // Random traffic against the model on both instances.
        for (int c = 0; c < 3000; c++) begin
            logic [8:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(500, 511)) : 9'($urandom_range(0, 15));
            op($urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 99) < 60,
               16'($urandom), 1'($urandom_range(0, 1)), ra);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
